// File: rtl/rom_port_arbiter.sv
// Two-port round-robin arbiter in front of the genrom read port.
// Define ROM_ARB_LOCK_EN to add the port-0 burst lock input rq_lock0.
module rom_port_arbiter #(
  parameter int AW      = 5,
  parameter int EXTRA   = 4,
  parameter int ROM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               rq_req,
  input  logic [AW:0]              rq_addr0,
  input  logic [AW:0]              rq_addr1,
  input  logic [EXTRA-1:0]         rq_extra0,
  input  logic [EXTRA-1:0]         rq_extra1,
  input  logic [AW:0]              rq_lo0,
  input  logic [AW:0]              rq_lo1,
  input  logic [AW:0]              rq_hi0,
  input  logic [AW:0]              rq_hi1,
`ifdef ROM_ARB_LOCK_EN
  input  logic                     rq_lock0,
`endif
  output logic [1:0]               rq_gnt,
  output logic [1:0]               rs_valid,
  output logic [(2**EXTRA)*8-1:0]  rs_data,
  output logic                     rs_error,
  output logic [AW:0]              mem_addr,
  output logic [EXTRA-1:0]         mem_extra,
  output logic [AW:0]              mem_lower_bound,
  output logic [AW:0]              mem_upper_bound,
  input  logic [(2**EXTRA)*8-1:0]  mem_data,
  input  logic                     mem_error
);

  localparam int L = ROM_LAT;

  logic         last;
  logic         lock;
  logic [1:0]   gnt;
  logic [L-1:0] tv;
  logic [L-1:0] tp;

`ifdef ROM_ARB_LOCK_EN
  logic gnt0_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) gnt0_q <= 1'b0;
    else        gnt0_q <= gnt[0];
  end

  assign lock = gnt0_q & rq_lock0 & rq_req[0];
`else
  assign lock = 1'b0;
`endif

  always_comb begin
    gnt = 2'b00;
    if (!reset)        gnt = 2'b00;
    else if (lock)     gnt = 2'b01;
    else if (&rq_req)  gnt = last ? 2'b01 : 2'b10;
    else               gnt = rq_req;
  end

  assign rq_gnt = gnt;

  always_comb begin
    mem_addr        = '0;
    mem_extra       = '0;
    mem_lower_bound = '0;
    mem_upper_bound = '0;
    unique case (1'b1)
      gnt[0]: begin
        mem_addr        = rq_addr0;
        mem_extra       = rq_extra0;
        mem_lower_bound = rq_lo0;
        mem_upper_bound = rq_hi0;
      end
      gnt[1]: begin
        mem_addr        = rq_addr1;
        mem_extra       = rq_extra1;
        mem_lower_bound = rq_lo1;
        mem_upper_bound = rq_hi1;
      end
      default: ;
    endcase
  end

  // tag shift register: bit 0 is the access granted at this edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last     <= 1'b1;
      tv       <= '0;
      tp       <= '0;
      rs_valid <= 2'b00;
      rs_data  <= '0;
      rs_error <= 1'b0;
    end else begin
      if (|gnt) last <= gnt[1];
      tv       <= L'({tv, |gnt});
      tp       <= L'({tp, gnt[1]});
      rs_valid <= {tv[L-1] & tp[L-1], tv[L-1] & ~tp[L-1]};
      if (tv[L-1]) begin
        rs_data  <= mem_data;
        rs_error <= mem_error;
      end
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter with a latency-1 genrom model.
// Byte k of the modelled ROM holds 0x3D+k; out-of-bounds reads return 0 with error.
module tb_rom_port_arbiter;

  localparam int AW = 5;
  localparam int EXTRA = 4;
  localparam int ROM_LAT = 1;
  localparam int DW = 128;

  typedef struct packed {
    logic [1:0] v;
    logic [7:0] d;
    logic       e;
  } rsp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    rq_req;
  logic [AW:0]   rq_addr0, rq_addr1;
  logic [3:0]    rq_extra0, rq_extra1;
  logic [AW:0]   rq_lo0, rq_lo1, rq_hi0, rq_hi1;
`ifdef ROM_ARB_LOCK_EN
  logic          rq_lock0;
`endif
  logic [1:0]    rq_gnt, rs_valid;
  logic [DW-1:0] rs_data;
  logic          rs_error;
  logic [AW:0]   mem_addr;
  logic [3:0]    mem_extra;
  logic [AW:0]   mem_lower_bound, mem_upper_bound;
  logic [DW-1:0] mem_data;
  logic          mem_error;

  int   checks = 0;
  int   errors = 0;
  rsp_t q[$];
  logic [7:0] exp_d[2];
  logic       exp_e[2];

  rom_port_arbiter #(.AW(AW), .EXTRA(EXTRA), .ROM_LAT(ROM_LAT)) dut (
    .clk(clk), .reset(reset), .rq_req(rq_req),
    .rq_addr0(rq_addr0), .rq_addr1(rq_addr1),
    .rq_extra0(rq_extra0), .rq_extra1(rq_extra1),
    .rq_lo0(rq_lo0), .rq_lo1(rq_lo1),
    .rq_hi0(rq_hi0), .rq_hi1(rq_hi1),
`ifdef ROM_ARB_LOCK_EN
    .rq_lock0(rq_lock0),
`endif
    .rq_gnt(rq_gnt), .rs_valid(rs_valid),
    .rs_data(rs_data), .rs_error(rs_error),
    .mem_addr(mem_addr), .mem_extra(mem_extra),
    .mem_lower_bound(mem_lower_bound),
    .mem_upper_bound(mem_upper_bound),
    .mem_data(mem_data), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  function automatic logic [DW:0] rom_rd(
    input logic [AW:0] a, input logic [3:0] x,
    input logic [AW:0] lo, input logic [AW:0] hi);
    logic [DW-1:0] d;
    d = '0;
    if (int'(a) < int'(lo) || int'(a) + int'(x) > int'(hi))
      return {1'b1, d};
    for (int j = 0; j < 16; j++)
      if (j <= int'(x)) d[j*8 +: 8] = 8'(8'h3D + int'(a) + j);
    return {1'b0, d};
  endfunction

  always @(posedge clk)
    {mem_error, mem_data} <= rom_rd(mem_addr, mem_extra,
                                    mem_lower_bound, mem_upper_bound);

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && rs_valid !== 2'b00) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp got %0b want none", rs_valid);
      end else begin
        rsp_t e;
        e = q.pop_front();
        chk("rsp_valid", 32'(rs_valid), 32'(e.v));
        chk("rsp_data", 32'(rs_data[7:0]), 32'(e.d));
        chk("rsp_error", 32'(rs_error), 32'(e.e));
      end
    end
  end

  task automatic set_port(input int p, input logic [AW:0] a,
                          input logic [3:0] x, input logic [AW:0] lo,
                          input logic [AW:0] hi, input logic [7:0] d,
                          input logic e);
    if (p == 0) begin
      rq_addr0 = a; rq_extra0 = x; rq_lo0 = lo; rq_hi0 = hi;
    end else begin
      rq_addr1 = a; rq_extra1 = x; rq_lo1 = lo; rq_hi1 = hi;
    end
    exp_d[p] = d;
    exp_e[p] = e;
  endtask

  task automatic cyc(input logic [1:0] eg, input bit push);
    @(negedge clk);
    chk("gnt", 32'(rq_gnt), 32'(eg));
    if (push && eg != 2'b00)
      q.push_back('{v: eg, d: exp_d[eg[1]], e: exp_e[eg[1]]});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    rq_req = 2'b11;
`ifdef ROM_ARB_LOCK_EN
    rq_lock0 = 1'b0;
`endif
    set_port(0, 6'h04, 4'd0, 6'h00, 6'h3F, 8'h41, 1'b0);
    set_port(1, 6'h10, 4'd0, 6'h00, 6'h3F, 8'h4D, 1'b0);
    @(negedge clk);
    chk("rst_gnt", 32'(rq_gnt), 32'd0);
    chk("rst_valid", 32'(rs_valid), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", 32'(rs_data[31:0]), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // contention: strict alternation starting with port 0
    for (int i = 0; i < 3; i++) begin
      cyc(2'b01, 1'b1);
      cyc(2'b10, 1'b1);
    end
    rq_req = 2'b00;
    drain();

    // single port 0 with exact response latency
    set_port(0, 6'h00, 4'd0, 6'h00, 6'h3F, 8'h3D, 1'b0);
    rq_req = 2'b01;
    cyc(2'b01, 1'b1);
    rq_req = 2'b00;
    for (int k = 0; k < ROM_LAT; k++) begin
      @(negedge clk);
      chk("lat_early", 32'(rs_valid), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("lat_resp", 32'(rs_valid), 32'b01);
    @(posedge clk);
    #1;
    drain();

    // error cases, back-to-back port 0 accesses
    set_port(1, 6'h20, 4'd0, 6'h00, 6'h1F, 8'h00, 1'b1);
    rq_req = 2'b10;
    cyc(2'b10, 1'b1);
    set_port(0, 6'h04, 4'd0, 6'h00, 6'h1F, 8'h41, 1'b0);
    rq_req = 2'b01;
    cyc(2'b01, 1'b1);
    set_port(0, 6'h1E, 4'd2, 6'h00, 6'h1F, 8'h00, 1'b1);
    cyc(2'b01, 1'b1);
    set_port(0, 6'h04, 4'd3, 6'h04, 6'h1F, 8'h41, 1'b0);
    cyc(2'b01, 1'b1);
    rq_req = 2'b00;
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("hold_data", 32'(rs_data[7:0]), 32'h41);
    chk("hold_err", 32'(rs_error), 32'd0);

    // reset while a port-1 access is in flight
    set_port(1, 6'h10, 4'd0, 6'h00, 6'h3F, 8'h4D, 1'b0);
    rq_req = 2'b10;
    cyc(2'b10, 1'b0);
    reset = 1'b0;
    rq_req = 2'b00;
    @(negedge clk);
    chk("mid_rst_gnt", 32'(rq_gnt), 32'd0);
    chk("mid_rst_valid", 32'(rs_valid), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(rs_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    set_port(0, 6'h04, 4'd0, 6'h00, 6'h3F, 8'h41, 1'b0);
    rq_req = 2'b11;
    cyc(2'b01, 1'b1);
    cyc(2'b10, 1'b1);
    rq_req = 2'b00;
    drain();

`ifdef ROM_ARB_LOCK_EN
    rq_req = 2'b11;
    cyc(2'b01, 1'b1);
    rq_lock0 = 1'b1;
    for (int k = 0; k < 3; k++) cyc(2'b01, 1'b1);
    rq_lock0 = 1'b0;
    cyc(2'b10, 1'b1);
    cyc(2'b01, 1'b1);
    rq_req = 2'b00;
    drain();
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single `genrom` read port between two requesters: port 0 is core instruction fetch, port 1 is the loader/debug reader.
- Drives `genrom` addr/extra/bounds and routes the returning data and error back to the requester that issued the access.
- Round-robin arbitration, one access issued per cycle, in-flight tracking over a fixed ROM latency.
- Sits between `core` and `genrom`.

Parameters:
- AW, 5: ROM address MSB index; address buses are AW+1 bits.
- EXTRA, 4: width of the `extra` field; data width is 2**EXTRA*8.
- ROM_LAT, 1: cycles from address sampled to `mem_data`/`mem_error` valid; legal range 1..4.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- rq_req  in  2  per-port request; bit i is port i.
- rq_addr0, rq_addr1  in  AW+1  per-port address.
- rq_extra0, rq_extra1  in  EXTRA  per-port extra bytes.
- rq_lo0, rq_lo1, rq_hi0, rq_hi1  in  AW+1  per-port lower/upper bound.
- rq_gnt  out  2  one-hot accept, this cycle.
- rs_valid  out  2  one-hot response valid.
- rs_data  out  2**EXTRA*8  response data, shared bus qualified by rs_valid.
- rs_error  out  1  response error, qualified by rs_valid.
- mem_addr  out  AW+1  to genrom addr.
- mem_extra  out  EXTRA  to genrom extra.
- mem_lower_bound, mem_upper_bound  out  AW+1  to genrom bounds.
- mem_data  in  2**EXTRA*8  from genrom.
- mem_error  in  1  from genrom.

Behaviour:
- Reset, while `reset` is 0:
  - rq_gnt=0, rs_valid=0, rs_data=0, rs_error=0, mem_* outputs=0.
  - Priority pointer `last` is set to 1, so port 0 wins first.
  - The in-flight tag pipeline is cleared.
- Arbitration (combinational in the current cycle):
  - Only port i requesting: grant i.
  - Both requesting: grant the port that is not `last`.
  - `last` is updated to the granted port on the clk edge.
  - No request: rq_gnt=0 and `last` is unchanged.
- Handshake:
  - The requester holds req/addr/extra/bounds stable until it sees gnt.
  - A transfer happens on a cycle where gnt is high.
  - The requester may keep req high to issue back-to-back accesses.
- mem_* outputs are a combinational mux of the granted port's fields. With no grant they are 0.
- Tag pipeline:
  - ROM_LAT stages, each {valid, port}.
  - Stage 0 loads {|rq_gnt, granted port} at each edge; the other stages shift.
  - The last stage drives rs_valid[port], registered with rs_data=mem_data and rs_error=mem_error.
  - Result: response arrives exactly ROM_LAT+1 edges after the grant edge.
  - rs_data and rs_error are held between responses.
- Throughput: one grant per cycle and no bubbles. Responses return in issue order.
- Simultaneous grant and response to the same port in one cycle is legal and independent.
- Reset mid-operation clears all in-flight tags. No rs_valid may appear for accesses granted before the reset.
- Reset deassertion is synchronized by the integrator; the block behaves correctly on the first edge after release.

Optional Feature:
- Macro: ROM_ARB_LOCK_EN.
- Defined:
  - Adds input `rq_lock0` (1 bit).
  - While port 0 was granted last cycle and rq_lock0=1 and rq_req[0]=1, port 0 wins regardless of `last`, giving the fetch unit an uninterrupted burst.
  - Lock has no effect if port 0 was not the previous grantee.
  - Port 1 gets the first grant after lock or req drops, if it is requesting.
- Undefined:
  - The port is absent and arbitration is pure round-robin.

Test Plan:
- Reset: reset=0 with rq_req=2'b11 -> rq_gnt=0, rs_valid=0, mem_addr=0. After release: first grant is port 0, then port 1.
- Single port, ROM_LAT=1:
  - Port 0 reads addr 0x04 (ROM byte 0x04=0x41) -> rq_gnt=2'b01 that cycle.
  - Response two edges later: rs_valid=2'b01, rs_data[7:0]=0x41, rs_error=0.
- Contention:
  - Both ports request continuously, port 0 addr 0x00, port 1 addr 0x10.
  - Grants alternate 01,10,01,10.
  - rs_valid follows the same pattern shifted by ROM_LAT+1.
  - Each response carries its own port's data.
- Error:
  - Port 1 reads addr 0x20 with rq_hi1=0x1F -> rs_valid=2'b10, rs_error=1.
  - Next port 0 response has rs_error=0.
- Reset mid-flight:
  - Grant port 1, assert reset before the response edge, release.
  - No rs_valid appears for that access.
  - Next grant goes to port 0.
- Lock (ROM_ARB_LOCK_EN):
  - Port 0 granted, then rq_lock0=1 for 3 cycles with both ports requesting -> four consecutive 2'b01 grants.
  - Drop rq_lock0 -> the next grant is 2'b10.
